// File: rtl/cb_dequantizer.sv
// Cb coefficient dequantizer: coef * Q[pos] with saturation to 11 bits, written into a
// double-buffered 8x8 block store that is handed to the IDCT as a whole block.
module cb_dequantizer #(
    parameter int         ZIGZAG_IN = 1,
    parameter logic [7:0] Q_RESET   = 8'd1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [10:0]            in_coef,
    input  logic                   q_we,
    input  logic [5:0]             q_addr,
    input  logic [7:0]             q_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0][7:0][10:0]  out_block,
    output logic                   out_sat
);

    localparam int COEF_W = 11;
    localparam int DATA_W = 11;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_FILL  = 2'b01;
    localparam logic [1:0] ST_PEND  = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Returns {saturated, value}; the 20-bit product never exceeds 19 significant bits.
    function automatic logic [DATA_W:0] sat_coef(input logic signed [19:0] p);
        if (p > 20'sd1023)
            return {1'b1, 11'h3FF};
        else if (p < -20'sd1024)
            return {1'b1, 11'h400};
        else
            return {1'b0, p[DATA_W-1:0]};
    endfunction

    logic [5:0]             idx_q;
    logic                   wbank_q, rbank_q;
    logic [1:0][1:0]        st_q, st_d;
    logic [1:0]             sat_q, sat_d;
    logic [63:0][7:0]       qtab_q;
    logic                   vld_p1, vld_p2;

    logic signed [COEF_W-1:0] coef_p1;
    logic [7:0]             q_p1;
    logic [5:0]             pos_p1, pos_p2;
    logic                   bank_p1, bank_p2;
    logic                   last_p1, last_p2;
    logic [DATA_W-1:0]      res_p2;
    logic                   satf_p2;
    logic [7:0][7:0][DATA_W-1:0] mem_q [2];

    logic                   xfer, rel;
    logic [5:0]             pos_d;
    logic signed [19:0]     prod_p1;
    logic [DATA_W:0]        sres_p1;

    assign in_ready  = (st_q[wbank_q] != ST_FULL) && (st_q[wbank_q] != ST_PEND);
    assign out_valid = (st_q[rbank_q] == ST_FULL);
    assign out_block = out_valid ? mem_q[rbank_q] : '0;
    assign out_sat   = out_valid & sat_q[rbank_q];

    assign xfer    = in_valid && in_ready;
    assign rel     = out_valid && out_ready;
    assign pos_d   = (ZIGZAG_IN != 0) ? ZZ[idx_q] : idx_q;
    assign prod_p1 = coef_p1 * $signed({1'b0, q_p1});
    assign sres_p1 = sat_coef(prod_p1);

    // A bank is PEND from its last transfer until coefficient 63 lands, which keeps in_ready honest.
    always_comb begin
        st_d  = st_q;
        sat_d = sat_q;
        if (xfer) begin
            if (idx_q == 6'd63)
                st_d[wbank_q] = ST_PEND;
            else if (st_q[wbank_q] == ST_EMPTY)
                st_d[wbank_q] = ST_FILL;
        end
        if (vld_p2 && last_p2)
            st_d[bank_p2] = ST_FULL;
        if (vld_p2 && satf_p2)
            sat_d[bank_p2] = 1'b1;
        if (rel) begin
            st_d[rbank_q]  = ST_EMPTY;
            sat_d[rbank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            st_q    <= {ST_EMPTY, ST_EMPTY};
            sat_q   <= '0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            qtab_q  <= {64{Q_RESET}};
        end else begin
            st_q   <= st_d;
            sat_q  <= sat_d;
            vld_p1 <= xfer;
            vld_p2 <= vld_p1;
            if (xfer) begin
                idx_q <= idx_q + 6'd1;
                if (idx_q == 6'd63)
                    wbank_q <= ~wbank_q;
            end
            if (rel)
                rbank_q <= ~rbank_q;
            if (q_we)
                qtab_q[q_addr] <= q_data;
        end
    end

    // S1: capture coefficient, raster position and the Q entry current at the transfer edge
    always_ff @(posedge clk) begin
        if (xfer) begin
            coef_p1 <= $signed(in_coef);
            pos_p1  <= pos_d;
            q_p1    <= qtab_q[pos_d];
            bank_p1 <= wbank_q;
            last_p1 <= (idx_q == 6'd63);
        end
    end

    // S2: exact product, saturated; leaves S2 into the block store on the following edge
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            res_p2  <= sres_p1[DATA_W-1:0];
            satf_p2 <= sres_p1[DATA_W];
            pos_p2  <= pos_p1;
            bank_p2 <= bank_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (vld_p2)
            mem_q[bank_p2][pos_p2[5:3]][pos_p2[2:0]] <= res_p2;
    end

endmodule

// File: tb/tb_cb_dequantizer.sv
// Directed bench for cb_dequantizer: zigzag streaming, Q-table loads, saturation,
// back-pressure across both banks, mid-block reset and same-edge Q write ordering.
module tb_cb_dequantizer;

    typedef logic [7:0][7:0][10:0] blk_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] in_coef = '0;
    logic        q_we = 1'b0;
    logic [5:0]  q_addr = '0;
    logic [7:0]  q_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    blk_t        out_block;
    logic        out_sat;

    int n_chk  = 0;
    int n_fail = 0;
    int zz [64];
    int vals [64];
    int qm [64];
    blk_t e0, e1, e2;

    cb_dequantizer #(.ZIGZAG_IN(1), .Q_RESET(8'd1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_coef(in_coef),
        .q_we(q_we), .q_addr(q_addr), .q_data(q_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_block(out_block), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input blk_t obs, input blk_t exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic blk_t expect_blk();
        blk_t e;
        int p;
        for (int i = 0; i < 64; i++) begin
            p = vals[i] * qm[i];
            if (p > 1023) p = 1023;
            if (p < -1024) p = -1024;
            e[i / 8][i % 8] = 11'(p);
        end
        return e;
    endfunction

    task automatic set_pat(input int b);
        for (int i = 0; i < 64; i++) vals[i] = b * 100 + i - 32;
    endtask

    task automatic clr_vals();
        for (int i = 0; i < 64; i++) vals[i] = 0;
    endtask

    task automatic qwrite(input int a, input int d);
        @(negedge clk);
        q_we = 1'b1; q_addr = 6'(a); q_data = 8'(d);
        @(posedge clk); #1;
        q_we = 1'b0;
        qm[a] = d;
    endtask

    // Streams the first n coefficients of vals in zigzag order; q write rides along with transfer qk.
    task automatic push(input int n, input int qk, input int qa, input int qd);
        int waited;
        bit done;
        for (int k = 0; k < n; k++) begin
            done = 1'b0;
            waited = 0;
            while (!done) begin
                @(negedge clk);
                in_valid = 1'b1;
                in_coef  = 11'(vals[zz[k]]);
                if (k == qk) begin
                    q_we = 1'b1; q_addr = 6'(qa); q_data = 8'(qd);
                end
                if (in_ready) done = 1'b1;
                else waited++;
                @(posedge clk); #1;
                q_we = 1'b0;
                if (waited > 300) begin
                    chk("push in_ready timeout", 0, 1);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic release_blk();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) qm[i] = 1;
    endtask

    initial begin
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 7 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[k] = r * 8 + (s - r); k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 7 ? s : 7); r++) begin
                    zz[k] = r * 8 + (s - r); k++;
                end
            end
        end
        for (int i = 0; i < 64; i++) qm[i] = 1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chkb("rst out_block", out_block, '0);
        chk("rst out_sat", out_sat, 0);
        rst = 1'b0;

        // T1: ramp in zigzag order, Q=1
        set_pat(0);
        e0 = expect_blk();
        push(64, -1, 0, 0);
        @(posedge clk); #1;
        chk("T1 valid 1 edge after", out_valid, 0);
        @(posedge clk); #1;
        chk("T1 valid 2 edges after", out_valid, 1);
        chkb("T1 block", out_block, e0);
        chk("T1 [0][0]", $signed(out_block[0][0]), -32);
        chk("T1 [7][7]", $signed(out_block[7][7]), 31);
        chk("T1 [2][3]", $signed(out_block[2][3]), -13);
        chk("T1 sat", out_sat, 0);
        release_blk();
        chk("T1 released", out_valid, 0);

        // T2: loaded Q entries at both corners
        qwrite(0, 16);
        qwrite(63, 99);
        clr_vals();
        vals[0] = -5; vals[63] = 7;
        e0 = expect_blk();
        push(64, -1, 0, 0);
        wait_valid("T2 valid");
        chk("T2 [0][0]", $signed(out_block[0][0]), -80);
        chk("T2 [7][7]", $signed(out_block[7][7]), 693);
        chkb("T2 block", out_block, e0);
        chk("T2 sat", out_sat, 0);
        release_blk();

        // T3: saturation both ways
        qwrite(1, 255);
        clr_vals();
        vals[1] = 100;
        push(64, -1, 0, 0);
        wait_valid("T3a valid");
        chk("T3a [0][1]", $signed(out_block[0][1]), 1023);
        chk("T3a sat", out_sat, 1);
        release_blk();
        vals[1] = -100;
        push(64, -1, 0, 0);
        wait_valid("T3b valid");
        chk("T3b [0][1]", $signed(out_block[0][1]), -1024);
        chk("T3b [0][0]", $signed(out_block[0][0]), 0);
        chk("T3b sat", out_sat, 1);
        release_blk();

        // T4: three blocks against a stalled consumer
        do_reset();
        set_pat(0); e0 = expect_blk();
        push(64, -1, 0, 0);
        set_pat(1); e1 = expect_blk();
        push(64, -1, 0, 0);
        chk("T4 in_ready after 128", in_ready, 0);
        chk("T4 valid", out_valid, 1);
        chkb("T4 block0", out_block, e0);
        repeat (5) @(posedge clk);
        #1;
        chkb("T4 block0 stable", out_block, e0);
        chk("T4 in_ready held low", in_ready, 0);
        chk("T4 sat", out_sat, 0);
        release_blk();
        chk("T4 valid block1", out_valid, 1);
        chkb("T4 block1", out_block, e1);
        chk("T4 in_ready back", in_ready, 1);
        set_pat(2); e2 = expect_blk();
        push(64, -1, 0, 0);
        release_blk();
        wait_valid("T4 valid block2");
        chkb("T4 block2", out_block, e2);
        release_blk();

        // T5: reset mid-block with a full bank waiting
        qwrite(5, 7);
        set_pat(0);
        push(64, -1, 0, 0);
        set_pat(3);
        push(30, -1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("T5 full bank pending", out_valid, 1);
        rst = 1'b1;
        #1;
        chk("T5 rst out_valid", out_valid, 0);
        chk("T5 rst in_ready", in_ready, 1);
        chkb("T5 rst out_block", out_block, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++) qm[i] = 1;
        set_pat(0); e0 = expect_blk();
        push(64, -1, 0, 0);
        wait_valid("T5 valid fresh");
        chk("T5 [0][5] Q reset", $signed(out_block[0][5]), -27);
        chkb("T5 fresh block", out_block, e0);
        release_blk();

        // T6: Q write on the same edge as the DC transfer
        clr_vals();
        vals[0] = 3;
        e0 = expect_blk();
        push(64, 0, 0, 2);
        qm[0] = 2;
        wait_valid("T6a valid");
        chk("T6a DC old Q", $signed(out_block[0][0]), 3);
        chkb("T6a block", out_block, e0);
        release_blk();
        e1 = expect_blk();
        push(64, -1, 0, 0);
        wait_valid("T6b valid");
        chk("T6b DC new Q", $signed(out_block[0][0]), 6);
        chkb("T6b block", out_block, e1);
        release_blk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
